// File: rtl/loader_scheduler.sv
// loader_scheduler: runs the loaders selected in load_mask one at a time,
// lowest index first, and gives the active loader exclusive use of the single
// CPU data link while it is in WAIT.
//
// Loader handshake: a loader is started by a one-cycle ld_sig_on pulse and owns
// the CPU link until it raises ld_sig_done; ld_sig_done is only honoured from
// the active loader while in WAIT, and every other loader sees zero CPU strobes.
module loader_scheduler #(
  parameter int num_loaders    = 4,
  parameter int timeout_cycles = 1000000
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       start,
  input  logic [num_loaders-1:0]     load_mask,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [2:0]                 active_index,
  output logic [num_loaders-1:0]     ld_sig_on,
  input  logic [num_loaders-1:0]     ld_sig_done,
  input  logic [num_loaders-1:0]     ld_restart,
  input  logic [num_loaders-1:0]     ld_request_data,
  input  logic [8*num_loaders-1:0]   ld_init_index,
  input  logic [8*num_loaders-1:0]   ld_init_aux_info,
  output logic [num_loaders-1:0]     ld_data_ready,
  output logic [num_loaders-1:0]     ld_transmit_finished,
  output logic [7:0]                 ld_cpu_data_in,
  output logic                       restart,
  output logic                       request_data,
  output logic [7:0]                 init_index,
  output logic [7:0]                 init_aux_info,
  input  logic                       data_ready,
  input  logic                       transmit_finished,
  input  logic [7:0]                 cpu_data_in
);

  // The timer only ever holds 0..timeout_cycles-1: the limit test comes first.
  localparam int timer_w = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam logic [timer_w-1:0] timer_last =
    timer_w'((timeout_cycles > 0) ? timeout_cycles - 1 : 0);
  localparam bit timeout_en = (timeout_cycles != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_FIRE   = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t                 state;
  logic [num_loaders-1:0] remaining;
  logic [timer_w-1:0]     timer;
  logic [2:0]             scan_index;
  logic [num_loaders-1:0] scan_onehot;
  logic [num_loaders-1:0] active_mask;
  logic                   in_wait;

  assign busy           = (state != S_IDLE);
  assign in_wait        = (state == S_WAIT);
  assign ld_cpu_data_in = cpu_data_in;

  // Lowest pending loader: walk downwards so the lowest set bit wins.
  always_comb begin
    scan_index  = '0;
    scan_onehot = '0;
    for (int i = num_loaders - 1; i >= 0; i--) begin
      if (remaining[i]) begin
        scan_index     = 3'(i);
        scan_onehot    = '0;
        scan_onehot[i] = 1'b1;
      end
    end
  end

  // One-hot view of active_index, used for selection and for clearing remaining.
  always_comb begin
    active_mask = '0;
    for (int i = 0; i < num_loaders; i++) begin
      if (active_index == 3'(i)) active_mask[i] = 1'b1;
    end
  end

  // Loader-to-CPU mux: only the active loader is visible, and only in WAIT.
  always_comb begin
    restart       = 1'b0;
    request_data  = 1'b0;
    init_index    = '0;
    init_aux_info = '0;
    for (int i = 0; i < num_loaders; i++) begin
      if (in_wait && active_mask[i]) begin
        restart       = ld_restart[i];
        request_data  = ld_request_data[i];
        init_index    = ld_init_index[8*i +: 8];
        init_aux_info = ld_init_aux_info[8*i +: 8];
      end
    end
  end

  // CPU-to-loader strobes go only to the active loader, and only in WAIT.
  always_comb begin
    ld_data_ready        = '0;
    ld_transmit_finished = '0;
    if (in_wait) begin
      ld_data_ready        = active_mask & {num_loaders{data_ready}};
      ld_transmit_finished = active_mask & {num_loaders{transmit_finished}};
    end
  end

  // Batch sequencer with registered sig_on/done/error pulses.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= S_IDLE;
      remaining    <= '0;
      timer        <= '0;
      active_index <= '0;
      ld_sig_on    <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      ld_sig_on <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= load_mask;
            state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (remaining == '0) begin
            done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            active_index <= scan_index;
            ld_sig_on    <= scan_onehot;
            state        <= S_FIRE;
          end
        end
        S_FIRE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Completion is checked first so it beats a same-cycle timeout.
          if (|(ld_sig_done & active_mask)) begin
            remaining <= remaining & ~active_mask;
            state     <= S_SCAN;
          end else if (timeout_en && (timer == timer_last)) begin
            remaining <= '0;
            error     <= 1'b1;
            state     <= S_IDLE;
          end else begin
            timer <= timer + timer_w'(1);
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
